// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order reads to instruction memory and buffers the returned
// words in a small FIFO for decode. Optional stall counter is enabled with IF_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];

  logic            req_fire, push, pop;
  logic [CntW:0]   credit_used;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Buffered plus in-flight words may never exceed the FIFO, so a response always has a slot.
  assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = !reset && (credit_used < DepthW) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = imem_rsp_valid && !redirect_valid && (discard_q == '0);
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid    = (count_q != '0);
  assign instr          = instr_valid ? fifo_instr_q[rd_ptr_q] : Nop;
  assign instr_pc       = instr_valid ? fifo_pc_q[rd_ptr_q] : 32'h0000_0000;
  assign instr_pc_plus4 = instr_pc + 32'd4;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q + CntW'(req_fire) - CntW'(imem_rsp_valid);
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      // Every read still in flight after this cycle belongs to the old path.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc[31:2], 2'b00};
      discard_d  = outst_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (imem_rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - CntW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: outputs are masked by instr_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
      fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!instr_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: randomized memory latency/backpressure/redirects
// checked against a sequential-PC reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, rsp_valid, redir_valid, instr_valid, instr_ready;
  logic [31:0] req_addr, rsp_data, redir_pc, instr, instr_pc, instr_pc4;
  logic        w_req_valid, w_req_ready, w_rsp_valid, w_redir_valid, w_instr_valid, w_instr_ready;
  logic [31:0] w_req_addr, w_rsp_data, w_redir_pc, w_instr, w_instr_pc, w_instr_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall, w_stall;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir_valid), .redirect_pc(redir_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc4)
`ifdef IF_PERF_CNT_EN
    , .stall_cycles(stall)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redir_valid), .redirect_pc(w_redir_pc),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr),
    .instr_pc(w_instr_pc), .instr_pc_plus4(w_instr_pc4)
`ifdef IF_PERF_CNT_EN
    , .stall_cycles(w_stall)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    bit          rsp;
    bit          req_v;
    logic [31:0] req_addr;
    bit          acc;
    bit          inv;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
    bit          pop;
  } obs_t;

  mreq_t mem_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  int    data_mode = 0;

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    case (data_mode)
      1:       return 32'hFFC4_A303;
      2:       return a[2] ? 32'h0062_E233 : 32'h0064_A423;
      default: return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endcase
  endfunction

  // One clock: called at a negedge, drives inputs, samples, advances to the next negedge.
  task automatic step(input bit rq_rdy, input bit in_rdy, input bit redir,
                      input logic [31:0] tgt, input int rsp_pct, output obs_t o);
    mreq_t m;
    o.rsp     = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc && int'($urandom_range(99)) < rsp_pct) begin
      rsp_valid = 1'b1;
      rsp_data  = data_of(mem_q[0].addr);
      void'(mem_q.pop_front());
      o.rsp = 1'b1;
    end
    req_ready   = rq_rdy;
    instr_ready = in_rdy;
    redir_valid = redir;
    redir_pc    = tgt;
    #1;
    o.req_v    = req_valid;
    o.req_addr = req_addr;
    o.acc      = req_valid && rq_rdy;
    o.inv      = instr_valid;
    o.ins      = instr;
    o.pc       = instr_pc;
    o.pc4      = instr_pc4;
    o.pop      = instr_valid && in_rdy && !redir;
    if (o.acc) begin
      m.addr = req_addr;
      m.due  = cyc + 1;
      mem_q.push_back(m);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    req_ready = 0; rsp_valid = 0; rsp_data = '0; redir_valid = 0; redir_pc = '0;
    instr_ready = 0;
    w_req_ready = 0; w_rsp_valid = 0; w_rsp_data = '0; w_redir_valid = 0; w_redir_pc = '0;
    w_instr_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    mem_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #1;
    tests++;
    if (req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== Nop || instr_pc !== 32'h0
        || instr_pc4 !== 32'h4) begin
      fails++;
      $display("FAIL reset_outputs: got rv=%b iv=%b instr=%h pc=%h pc4=%h, want 0 0 %h 0 4",
               req_valid, instr_valid, instr, instr_pc, instr_pc4, Nop);
    end
    tests++;
    if (w_instr_pc !== 32'h0 || w_instr_pc4 !== 32'h4 || w_instr !== Nop) begin
      fails++;
      $display("FAIL reset_wrap_outputs: got pc=%h pc4=%h instr=%h, want 0 4 %h",
               w_instr_pc, w_instr_pc4, w_instr, Nop);
    end
`ifdef IF_PERF_CNT_EN
    tests++;
    if (stall !== 32'h0) begin
      fails++;
      $display("FAIL reset_stall: got %h want 0", stall);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
      fails++;
      $display("FAIL first_request: got v=%b addr=%h want 1 00000000", req_valid, req_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    obs_t o;
    logic [31:0] exp_fetch = 32'h0, exp_pc = 32'h0;
    int npop = 0, first_rsp = -1, first_inv = -1;
    data_mode = 1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 100, o);
      if (o.rsp && first_rsp < 0) first_rsp = i;
      if (o.inv && first_inv < 0) first_inv = i;
      if (o.acc) begin
        tests++;
        if (o.req_addr !== exp_fetch) begin
          fails++;
          $display("FAIL stream_addr: got %h want %h", o.req_addr, exp_fetch);
        end
        exp_fetch += 32'd4;
      end
      if (o.pop) begin
        tests++;
        if (o.pc !== exp_pc || o.ins !== data_of(exp_pc) || o.pc4 !== exp_pc + 32'd4) begin
          fails++;
          $display("FAIL stream_word: got pc=%h instr=%h pc4=%h want %h %h %h",
                   o.pc, o.ins, o.pc4, exp_pc, data_of(exp_pc), exp_pc + 32'd4);
        end
        exp_pc += 32'd4;
        npop++;
      end else if (!o.inv) begin
        tests++;
        if (o.ins !== Nop) begin
          fails++;
          $display("FAIL stream_nop: got %h want %h", o.ins, Nop);
        end
      end
    end
    tests++;
    if (first_rsp < 0 || first_inv != first_rsp + 1) begin
      fails++;
      $display("FAIL stream_latency: got valid at %0d want %0d", first_inv, first_rsp + 1);
    end
    tests++;
    if (npop < 20) begin
      fails++;
      $display("FAIL stream_throughput: got %0d pops want >= 20", npop);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    logic [31:0] exp_pc = 32'h0;
    int nacc = 0, npop = 0;
    data_mode = 2;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 100, o);
      if (o.acc) nacc++;
    end
    tests++;
    if (o.req_v !== 1'b0 || o.inv !== 1'b1 || nacc != 2) begin
      fails++;
      $display("FAIL bp_full: got rv=%b iv=%b accepts=%0d want 0 1 2", o.req_v, o.inv, nacc);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 100, o);
      if (o.pop) begin
        tests++;
        if (o.pc !== exp_pc || o.ins !== data_of(exp_pc)) begin
          fails++;
          $display("FAIL bp_order: got pc=%h instr=%h want %h %h",
                   o.pc, o.ins, exp_pc, data_of(exp_pc));
        end
        exp_pc += 32'd4;
        npop++;
      end
    end
    tests++;
    if (npop < 4) begin
      fails++;
      $display("FAIL bp_drain: got %0d pops want >= 4", npop);
    end
  endtask

  task automatic test_redirect();
    obs_t o;
    logic [31:0] exp_fetch = 32'h100, exp_pc = 32'h100;
    int npop = 0;
    data_mode = 0;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 0, o);
    step(1'b1, 1'b0, 1'b0, 32'h0, 0, o);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0103, 0, o);
    tests++;
    if (o.req_v !== 1'b0 || mem_q.size() != 2) begin
      fails++;
      $display("FAIL redir_setup: got rv=%b inflight=%0d want 0 2", o.req_v, mem_q.size());
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 100, o);
      if (o.acc) begin
        tests++;
        if (o.req_addr !== exp_fetch) begin
          fails++;
          $display("FAIL redir_addr: got %h want %h", o.req_addr, exp_fetch);
        end
        exp_fetch += 32'd4;
      end
      if (o.pop) begin
        tests++;
        if (o.pc !== exp_pc || o.ins !== data_of(exp_pc)) begin
          fails++;
          $display("FAIL redir_word: got pc=%h instr=%h want %h %h",
                   o.pc, o.ins, exp_pc, data_of(exp_pc));
        end
        exp_pc += 32'd4;
        npop++;
      end
    end
    tests++;
    if (npop == 0) begin
      fails++;
      $display("FAIL redir_progress: got 0 pops want > 0");
    end
  endtask

  task automatic test_redirect_same_cycle();
    obs_t o;
    logic [31:0] exp_fetch = 32'h200, exp_pc = 32'h200;
    data_mode = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 100, o);
    step(1'b1, 1'b1, 1'b0, 32'h0, 100, o);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 100, o);
    tests++;
    if (o.rsp !== 1'b1 || o.inv !== 1'b1) begin
      fails++;
      $display("FAIL collide_setup: got rsp=%b iv=%b want 1 1", o.rsp, o.inv);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0, 100, o);
    tests++;
    if (o.inv !== 1'b0 || o.ins !== Nop) begin
      fails++;
      $display("FAIL collide_flush: got iv=%b instr=%h want 0 %h", o.inv, o.ins, Nop);
    end
    if (o.acc) begin
      tests++;
      if (o.req_addr !== exp_fetch) begin
        fails++;
        $display("FAIL collide_target: got %h want %h", o.req_addr, exp_fetch);
      end
      exp_fetch += 32'd4;
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 100, o);
      if (o.acc) begin
        tests++;
        if (o.req_addr !== exp_fetch) begin
          fails++;
          $display("FAIL collide_addr: got %h want %h", o.req_addr, exp_fetch);
        end
        exp_fetch += 32'd4;
      end
      if (o.pop) begin
        tests++;
        if (o.pc !== exp_pc || o.ins !== data_of(exp_pc)) begin
          fails++;
          $display("FAIL collide_word: got pc=%h instr=%h want %h %h",
                   o.pc, o.ins, exp_pc, data_of(exp_pc));
        end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [31:0] exp_fetch = 32'h0, exp_pc = 32'h0, tgt;
    bit redir, prev_redir = 1'b0;
    int npop = 0;
    data_mode = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      redir = ($urandom_range(15) == 0) || (prev_redir && $urandom_range(1) == 1);
      tgt   = $urandom;
      step($urandom_range(3) != 0, $urandom_range(3) != 0, redir, tgt, 70, o);
      if (o.acc) begin
        tests++;
        if (o.req_addr !== exp_fetch) begin
          fails++;
          $display("FAIL rand_addr: cycle %0d got %h want %h", i, o.req_addr, exp_fetch);
        end
        exp_fetch += 32'd4;
      end
      if (redir) begin
        tests++;
        if (o.req_v !== 1'b0) begin
          fails++;
          $display("FAIL rand_req_in_redirect: got %b want 0", o.req_v);
        end
      end
      if (o.pop) begin
        tests++;
        if (o.pc !== exp_pc || o.ins !== data_of(exp_pc) || o.pc4 !== exp_pc + 32'd4) begin
          fails++;
          $display("FAIL rand_word: cycle %0d got pc=%h instr=%h pc4=%h want %h %h %h", i,
                   o.pc, o.ins, o.pc4, exp_pc, data_of(exp_pc), exp_pc + 32'd4);
        end
        exp_pc += 32'd4;
        npop++;
      end else if (!o.inv) begin
        tests++;
        if (o.ins !== Nop) begin
          fails++;
          $display("FAIL rand_nop: got %h want %h", o.ins, Nop);
        end
      end
      tests++;
      if (mem_q.size() > 2) begin
        fails++;
        $display("FAIL rand_inflight: got %0d want <= 2", mem_q.size());
      end
      if (redir) begin
        exp_fetch = {tgt[31:2], 2'b00};
        exp_pc    = {tgt[31:2], 2'b00};
      end
      prev_redir = redir;
    end
    tests++;
    if (npop < 100) begin
      fails++;
      $display("FAIL rand_progress: got %0d pops want >= 100", npop);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_fetch = 32'hFFFF_FFF8, exp_pc = 32'hFFFF_FFF8, pend_addr = '0;
    bit pend = 1'b0;
    int npop = 0;
    data_mode = 0;
    do_reset();
    w_req_ready   = 1'b1;
    w_instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      w_rsp_valid = pend;
      w_rsp_data  = data_of(pend_addr);
      #1;
      pend = w_req_valid;
      pend_addr = w_req_addr;
      if (w_req_valid) begin
        tests++;
        if (w_req_addr !== exp_fetch) begin
          fails++;
          $display("FAIL wrap_addr: got %h want %h", w_req_addr, exp_fetch);
        end
        exp_fetch += 32'd4;
      end
      if (w_instr_valid) begin
        tests++;
        if (w_instr_pc !== exp_pc || w_instr !== data_of(exp_pc)
            || w_instr_pc4 !== exp_pc + 32'd4) begin
          fails++;
          $display("FAIL wrap_word: got pc=%h instr=%h pc4=%h want %h %h %h", w_instr_pc,
                   w_instr, w_instr_pc4, exp_pc, data_of(exp_pc), exp_pc + 32'd4);
        end
        exp_pc += 32'd4;
        npop++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_instr_ready = 1'b0;
    tests++;
    if (npop < 3) begin
      fails++;
      $display("FAIL wrap_progress: got %0d pops want >= 3", npop);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit saw_valid = 1'b0;
    data_mode = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 100, o);
      if (o.inv) saw_valid = 1'b1;
    end
    reset = 1'b1;
    idle_inputs();
    mem_q.delete();
    #1;
    tests++;
    if (!saw_valid || req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== Nop
        || instr_pc !== 32'h0 || instr_pc4 !== 32'h4) begin
      fails++;
      $display("FAIL midreset_outputs: got seen=%b rv=%b iv=%b instr=%h pc=%h pc4=%h",
               saw_valid, req_valid, instr_valid, instr, instr_pc, instr_pc4);
    end
`ifdef IF_PERF_CNT_EN
    tests++;
    if (stall !== 32'h0) begin
      fails++;
      $display("FAIL midreset_stall_clear: got %h want 0", stall);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 100, o);
      tests++;
      if (o.inv !== 1'b0 || o.req_v !== 1'b1 || o.req_addr !== 32'h0) begin
        fails++;
        $display("FAIL midreset_hold: got iv=%b rv=%b addr=%h want 0 1 0",
                 o.inv, o.req_v, o.req_addr);
      end
    end
`ifdef IF_PERF_CNT_EN
    tests++;
    if (stall !== 32'd10) begin
      fails++;
      $display("FAIL stall_count: got %0d want 10", stall);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_same_cycle();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
